// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared types and constants for the two-master AXI4-Lite arbiter.
package axi_lite_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 32;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} arb_state_t;
endpackage

// File: rtl/arb2_pick.sv
// arb2_pick: two-way grant selection; ARB_FIXED_PRIO_EN makes master 0 win every tie.
module arb2_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_next
);
`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_grant;
    assign grant_next = req1 & ~req0;
`else
    assign grant_next = (req0 & req1) ? ~last_grant : req1;
`endif
endmodule

// File: rtl/axi_lite_arb2.sv
// axi_lite_arb2: two-master AXI4-Lite arbiter, one whole transaction per grant.
// ARB_FIXED_PRIO_EN selects fixed priority (master 0) instead of round-robin.
module axi_lite_arb2 import axi_lite_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_wstrb,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    output logic [1:0]        m0_bresp,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_wstrb,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic [1:0]        m1_bresp,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    output logic [ADDR_W-1:0] s_axi_araddr,
    output logic              s_axi_arvalid,
    input  logic              s_axi_arready,
    input  logic [DATA_W-1:0] s_axi_rdata,
    input  logic [1:0]        s_axi_rresp,
    input  logic              s_axi_rvalid,
    output logic              s_axi_rready,
    output logic [ADDR_W-1:0] s_axi_awaddr,
    output logic              s_axi_awvalid,
    input  logic              s_axi_awready,
    output logic [DATA_W-1:0] s_axi_wdata,
    output logic [3:0]        s_axi_wstrb,
    output logic              s_axi_wvalid,
    input  logic              s_axi_wready,
    input  logic [1:0]        s_axi_bresp,
    input  logic              s_axi_bvalid,
    output logic              s_axi_bready,
    output logic              grant,
    output logic              busy
);
    arb_state_t state;
    logic aw_done, w_done, last_grant, grant_next, req0, req1, win_wr;
    logic st_ar, st_r, st_aw, st_b, g0, g1;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign req0 = m0_arvalid | m0_awvalid;
    assign req1 = m1_arvalid | m1_awvalid;

    arb2_pick u_pick (.req0, .req1, .last_grant, .grant_next);

    assign win_wr = grant_next ? m1_awvalid : m0_awvalid;
    assign st_ar = state == RD_ADDR;
    assign st_r = state == RD_DATA;
    assign st_aw = state == WR_ADDR;
    assign st_b = state == WR_RESP;
    assign busy = state != IDLE;
    assign g0 = ~grant;
    assign g1 = grant;

    assign s_axi_araddr = grant ? m1_araddr : m0_araddr;
    assign s_axi_awaddr = grant ? m1_awaddr : m0_awaddr;
    assign s_axi_wdata = grant ? m1_wdata : m0_wdata;
    assign s_axi_wstrb = grant ? m1_wstrb : m0_wstrb;
    assign s_axi_arvalid = st_ar & (grant ? m1_arvalid : m0_arvalid);
    assign s_axi_rready = st_r & (grant ? m1_rready : m0_rready);
    // a write channel already accepted is masked so no second beat reaches the slave
    assign s_axi_awvalid = st_aw & ~aw_done & (grant ? m1_awvalid : m0_awvalid);
    assign s_axi_wvalid = st_aw & ~w_done & (grant ? m1_wvalid : m0_wvalid);
    assign s_axi_bready = st_b & (grant ? m1_bready : m0_bready);

    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign r_hs = s_axi_rvalid & s_axi_rready;
    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs = s_axi_wvalid & s_axi_wready;
    assign b_hs = s_axi_bvalid & s_axi_bready;

    assign m0_arready = g0 & st_ar & s_axi_arready;
    assign m0_rvalid = g0 & st_r & s_axi_rvalid;
    assign m0_awready = g0 & st_aw & ~aw_done & s_axi_awready;
    assign m0_wready = g0 & st_aw & ~w_done & s_axi_wready;
    assign m0_bvalid = g0 & st_b & s_axi_bvalid;
    assign m1_arready = g1 & st_ar & s_axi_arready;
    assign m1_rvalid = g1 & st_r & s_axi_rvalid;
    assign m1_awready = g1 & st_aw & ~aw_done & s_axi_awready;
    assign m1_wready = g1 & st_aw & ~w_done & s_axi_wready;
    assign m1_bvalid = g1 & st_b & s_axi_bvalid;
    assign m0_rdata = s_axi_rdata;
    assign m1_rdata = s_axi_rdata;
    assign m0_rresp = s_axi_rresp;
    assign m1_rresp = s_axi_rresp;
    assign m0_bresp = s_axi_bresp;
    assign m1_bresp = s_axi_bresp;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            grant <= 1'b0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    grant <= grant_next;
                    state <= win_wr ? WR_ADDR : RD_ADDR;
                end
                RD_ADDR: if (ar_hs) state <= RD_DATA;
                RD_DATA: if (r_hs) state <= IDLE;
                WR_ADDR: begin
                    aw_done <= aw_done | aw_hs;
                    w_done <= w_done | w_hs;
                    if ((aw_done | aw_hs) & (w_done | w_hs)) state <= WR_RESP;
                end
                WR_RESP: if (b_hs) begin
                    aw_done <= 1'b0;
                    w_done <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    assign last_grant = 1'b1;
`else
    // pointer starts at 1 so master 0 wins the first tie
    always_ff @(posedge clk) begin
        if (!rstn) last_grant <= 1'b1;
        else if (r_hs | b_hs) last_grant <= grant;
    end
`endif
endmodule

// File: tb/tb_axi_lite_arb2.sv
// tb_axi_lite_arb2: random two-master traffic through axi_lite_arb2 into a behavioural slave,
// checked by a scoreboard of per-master requests and an arbitration-order queue.
`timescale 1ns/1ps
module tb_axi_lite_arb2;
    import axi_lite_pkg::*;
    typedef struct packed {logic wr; logic [3:0] addr; logic [31:0] data; logic [3:0] strb;} rec_t;

    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] arvalid = '0, rready = '0, awvalid = '0, wvalid = '0, bready = '0;
    logic [3:0] araddr[2], awaddr[2], wstrb[2];
    logic [31:0] wdata[2];
    logic m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid;
    logic m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0] m0_rresp, m1_rresp, m0_bresp, m1_bresp;
    logic [1:0] m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [31:0] m_rdata[2];
    logic [1:0] m_rresp[2], m_bresp[2];
    logic [3:0] s_araddr, s_awaddr, s_wstrb;
    logic [31:0] s_wdata;
    logic s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, grant, busy;
    logic s_arready = 0, s_rvalid = 0, s_awready = 0, s_wready = 0, s_bvalid = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0] s_rresp = '0, s_bresp = '0;

    assign m_arready = {m1_arready, m0_arready};
    assign m_rvalid = {m1_rvalid, m0_rvalid};
    assign m_awready = {m1_awready, m0_awready};
    assign m_wready = {m1_wready, m0_wready};
    assign m_bvalid = {m1_bvalid, m0_bvalid};
    assign m_rdata[0] = m0_rdata;
    assign m_rdata[1] = m1_rdata;
    assign m_rresp[0] = m0_rresp;
    assign m_rresp[1] = m1_rresp;
    assign m_bresp[0] = m0_bresp;
    assign m_bresp[1] = m1_bresp;

    axi_lite_arb2 dut (
        .clk(clk), .rstn(rstn),
        .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(rready[0]),
        .m0_awaddr(awaddr[0]), .m0_awvalid(awvalid[0]), .m0_awready(m0_awready),
        .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wvalid(wvalid[0]), .m0_wready(m0_wready),
        .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(bready[0]),
        .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(rready[1]),
        .m1_awaddr(awaddr[1]), .m1_awvalid(awvalid[1]), .m1_awready(m1_awready),
        .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wvalid(wvalid[1]), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(bready[1]),
        .s_axi_araddr(s_araddr), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .s_axi_awaddr(s_awaddr), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
        .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
        .grant(grant), .busy(busy)
    );

    int vecs = 0, errs = 0;
    rec_t rq[2][$];
    bit win_q[$];
    bit dir_mode = 0, hold_b = 0, s_aw_got = 0, s_w_got = 0;
    bit free = 1, last = 1, r_pend = 0, b_pend = 0;
    bit keep_w[2], aw_ok[2], w_ok[2];
    int ph[2], gap[2], left[2];
    int r_cnt = 0, b_cnt = 0;
    logic [3:0] b_addr = '0;

    // slave behaviour: read data and responses are a fixed function of the address
    function automatic logic [31:0] f_rdata(input logic [3:0] a);
        return {a ^ 4'h8, 28'h000_0001};
    endfunction
    function automatic logic [1:0] f_resp(input logic [3:0] a);
        return a[0] ? RESP_SLVERR : RESP_OKAY;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int i, input rec_t r);
        rq[i].push_back(r);
        if (r.wr) begin
            awaddr[i] = r.addr; wdata[i] = r.data; wstrb[i] = r.strb;
            awvalid[i] = 1; wvalid[i] = 1; aw_ok[i] = 0; w_ok[i] = 0;
            keep_w[i] = 1'($urandom % 2);
            ph[i] = 3;
        end else begin
            araddr[i] = r.addr; arvalid[i] = 1; ph[i] = 1;
        end
    endtask

    task automatic cycle();
        logic [1:0] h_ar, h_r, h_aw, h_w, h_b, req;
        logic sar, sr, saw, sw, sb;
        logic [3:0] sa, swa;
        bit win;
        @(negedge clk);
        h_ar = arvalid & m_arready; h_r = m_rvalid & rready; h_aw = awvalid & m_awready;
        h_w = wvalid & m_wready; h_b = m_bvalid & bready;
        sar = s_arvalid & s_arready; sr = s_rvalid & s_rready; saw = s_awvalid & s_awready;
        sw = s_wvalid & s_wready; sb = s_bvalid & s_bready;
        sa = s_araddr; swa = s_awaddr;
        req = arvalid | awvalid;
        // reference arbitration: decide once the previous transaction has finished
        if (free && req != 0) begin
`ifdef ARB_FIXED_PRIO_EN
            win = req[1] & ~req[0];
`else
            win = (req == 2'b11) ? ~last : req[1];
`endif
            win_q.push_back(win);
            last = win;
            free = 0;
        end
        if ((h_r | h_b) != 0) free = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (ph[i] == 0) begin
                if (gap[i] > 0) gap[i]--;
                else if (left[i] > 0) begin
                    rec_t r;
                    r.wr = 1'($urandom % 2); r.addr = 4'($urandom); r.data = $urandom; r.strb = 4'($urandom);
                    left[i]--;
                    issue(i, r);
                end
            end else if (ph[i] == 1) begin
                if (h_ar[i]) begin arvalid[i] = 0; ph[i] = 2; end
            end else if (ph[i] == 2) begin
                if (h_r[i]) begin ph[i] = 0; gap[i] = $urandom % 4; end
            end else if (ph[i] == 3) begin
                if (h_aw[i]) begin awvalid[i] = 0; aw_ok[i] = 1; end
                if (h_w[i]) begin w_ok[i] = 1; if (!keep_w[i]) wvalid[i] = 0; end
                if (aw_ok[i] && w_ok[i]) begin wvalid[i] = 0; ph[i] = 4; end
            end else if (h_b[i]) begin
                ph[i] = 0; gap[i] = $urandom % 4;
            end
            rready[i] = dir_mode | 1'($urandom % 2);
            bready[i] = dir_mode | 1'($urandom % 2);
        end
        s_arready = dir_mode | 1'($urandom % 2);
        s_awready = dir_mode | 1'($urandom % 2);
        s_wready = dir_mode | 1'($urandom % 2);
        if (sar) begin
            r_pend = 1; r_cnt = dir_mode ? 2 : $urandom % 3;
            s_rdata = f_rdata(sa); s_rresp = f_resp(sa); s_rvalid = r_cnt == 0;
        end else if (r_pend) begin
            if (sr) begin r_pend = 0; s_rvalid = 0; end
            else if (r_cnt > 0) begin r_cnt--; s_rvalid = r_cnt == 0; end
        end
        if (sb) begin
            s_aw_got = 0; s_w_got = 0; b_pend = 0; s_bvalid = 0;
        end else begin
            if (saw) begin s_aw_got = 1; b_addr = swa; end
            if (sw) s_w_got = 1;
            if (s_aw_got && s_w_got && !b_pend) begin b_pend = 1; b_cnt = $urandom % 3; end
            else if (b_pend && b_cnt > 0) b_cnt--;
            s_bvalid = b_pend && b_cnt == 0 && !hold_b;
            s_bresp = f_resp(b_addr);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_handshakes"}, {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
            m_arready, m_rvalid, m_awready, m_wready, m_bvalid}, 0);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a handshake
    initial begin
        int busy_n = 0;
        rec_t e;
        bit g;
        logic any0, any1;
        forever begin
            @(negedge clk);
            if (!rstn) busy_n = 0;
            else begin
                busy_n = busy ? busy_n + 1 : 0;
                if (!busy) chk("idle_quiet", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
                    m_arready, m_rvalid, m_awready, m_wready, m_bvalid}, 0);
                any0 = m0_arready | m0_rvalid | m0_awready | m0_wready | m0_bvalid;
                any1 = m1_arready | m1_rvalid | m1_awready | m1_wready | m1_bvalid;
                if (any0 | any1) chk("one_master_only", any0 & any1, 0);
                if (s_aw_got) chk("aw_masked", s_awvalid, 0);
                if (s_w_got) chk("w_masked", s_wvalid, 0);
                if ((s_arvalid & s_arready) | (s_awvalid & s_awready) | (s_wvalid & s_wready)) begin
                    chk("slave_txn_expected", 32'(win_q.size() > 0 && rq[win_q[0]].size() > 0), 1);
                    if (win_q.size() > 0 && rq[win_q[0]].size() > 0) begin
                        g = win_q[0];
                        e = rq[g][0];
                        chk("grant", grant, g);
                        if (s_arvalid & s_arready) begin chk("ar_is_read", e.wr, 0); chk("araddr", s_araddr, e.addr); end
                        if (s_awvalid & s_awready) begin chk("aw_is_write", e.wr, 1); chk("awaddr", s_awaddr, e.addr); end
                        if (s_wvalid & s_wready) begin chk("wdata", s_wdata, e.data); chk("wstrb", s_wstrb, e.strb); end
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if ((m_rvalid[i] & rready[i]) | (m_bvalid[i] & bready[i])) begin
                        chk("resp_expected", 32'(win_q.size() > 0 && rq[i].size() > 0), 1);
                        if (win_q.size() > 0 && rq[i].size() > 0) begin
                            chk("resp_master", i, win_q[0]);
                            void'(win_q.pop_front());
                            e = rq[i].pop_front();
                            if (m_rvalid[i]) begin
                                chk("r_on_read", e.wr, 0);
                                chk("rdata", m_rdata[i], f_rdata(e.addr));
                                chk("rresp", m_rresp[i], f_resp(e.addr));
                                if (dir_mode) chk("busy_cycles", busy_n, 4);
                            end else begin
                                chk("b_on_write", e.wr, 1);
                                chk("bresp", m_bresp[i], f_resp(e.addr));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vecs);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            araddr[i] = '0; awaddr[i] = '0; wstrb[i] = '0; wdata[i] = '0;
            ph[i] = 0; gap[i] = 0; left[i] = 0; keep_w[i] = 0; aw_ok[i] = 0; w_ok[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_grant", grant, 0);
        chk_quiet("reset");
        rstn = 1;
        // directed single read from m0 at 0x8, slave answers 2 cycles after AR
        dir_mode = 1;
        issue(0, '{wr: 1'b0, addr: 4'h8, data: 32'h0, strb: 4'h0});
        for (int c = 0; c < 30 && ph[0] != 0; c++) cycle();
        chk("dir_read_done", ph[0], 0);
        dir_mode = 0;
        // random traffic from both masters
        left[0] = 80; left[1] = 80;
        for (int c = 0; c < 20000 && !(ph[0] == 0 && ph[1] == 0 && left[0] == 0 && left[1] == 0); c++) cycle();
        chk("random_drained", {ph[0][3:0], ph[1][3:0], left[0][7:0], left[1][7:0]}, 0);
        repeat (2) cycle();
        // reset while m0 write waits in the response phase
        hold_b = 1;
        issue(0, '{wr: 1'b1, addr: 4'h2, data: 32'h0000_0041, strb: 4'hf});
        for (int c = 0; c < 60 && ph[0] != 4; c++) cycle();
        chk("wr_reached_resp", ph[0], 4);
        repeat (2) cycle();
        chk("wr_resp_busy", busy, 1);
        rstn = 0;
        cycle();
        arvalid = '0; awvalid = '0; wvalid = '0;
        ph[0] = 0; ph[1] = 0;
        rq[0].delete(); rq[1].delete(); win_q.delete();
        free = 1; last = 1; hold_b = 0; r_pend = 0; b_pend = 0;
        s_aw_got = 0; s_w_got = 0; s_rvalid = 0; s_bvalid = 0;
        rstn = 1;
        @(negedge clk);
        chk("post_reset_grant", grant, 0);
        chk_quiet("post_reset");
        @(posedge clk);
        #1;
        issue(1, '{wr: 1'b1, addr: 4'h4, data: 32'h0000_0042, strb: 4'h1});
        for (int c = 0; c < 60 && ph[1] != 0; c++) cycle();
        chk("m1_write_after_reset", ph[1], 0);
        chk("scoreboard_empty", {rq[0].size() == 0, rq[1].size() == 0, win_q.size() == 0}, 3'b111);
        repeat (3) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
